huff_bit_packer: RTL and testbench

// Downstream stage of the Huffman encoder. Captures the per-character code table the encoder

---
 rtl/huff_bit_packer.sv | 204 ++++++++++++++++++++
 tb/tb_huff_bit_packer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_bit_packer.sv
// rtl/huff_bit_packer.sv - packs Huffman codes of a raw character stream into fixed-width words
module huff_bit_packer #(
    parameter int MAX_CHAR_COUNT = 3,
    parameter int CODE_W         = 3,
    parameter int OUT_W          = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tbl_load,
    input  logic [MAX_CHAR_COUNT*8-1:0]      tbl_char,
    input  logic [MAX_CHAR_COUNT*CODE_W-1:0] tbl_code,
    input  logic [MAX_CHAR_COUNT*CODE_W-1:0] tbl_mask,
    input  logic                             sym_valid,
    output logic                             sym_ready,
    input  logic [7:0]                       sym_char,
    input  logic                             sym_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic [$clog2(OUT_W+1)-1:0]       out_nbits,
    output logic                             out_last,
    output logic                             miss_err
);
    // Accumulator must hold a full word minus one bit plus the longest code.
    localparam int ACC_W  = OUT_W + CODE_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int LEN_W  = $clog2(CODE_W + 1);
    localparam int NB_W   = $clog2(OUT_W + 1);
    localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] ACC_W_F  = FILL_W'(ACC_W);
    localparam logic [NB_W-1:0]   OUT_W_NB = NB_W'(OUT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [MAX_CHAR_COUNT*8-1:0]      tbl_char_q;
    logic [MAX_CHAR_COUNT*CODE_W-1:0] tbl_code_q;
    logic [MAX_CHAR_COUNT*CODE_W-1:0] tbl_mask_q;
    logic [ACC_W-1:0]                 acc_q, acc_d, acc_app;
    logic [FILL_W-1:0]                fill_q, fill_d, fill_app;
    logic                             out_valid_q, ov_d;
    logic [OUT_W-1:0]                 out_data_q, od_d;
    logic [NB_W-1:0]                  out_nbits_q, onb_d;
    logic                             out_last_q, ol_d;
    logic                             miss_q, miss_d;

    logic                             hit;
    logic [CODE_W-1:0]                hit_code, hit_mask;
    logic [LEN_W-1:0]                 hit_len;
    logic [FILL_W-1:0]                len_ext, shamt;
    logic [ACC_W-1:0]                 code_ext;
    logic                             accept, slot_free, flushing;

    assign sym_ready = (state_q == RUN) && (fill_q < OUT_W_F);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_nbits = out_nbits_q;
    assign out_last  = out_last_q;
    assign miss_err  = miss_q;

    assign accept    = sym_valid && sym_ready;
    assign slot_free = !out_valid_q || out_ready;
    assign flushing  = (state_q == FLUSH) || (accept && sym_last);

    // Table lookup: scan from the top so the lowest matching index wins; length is popcount of mask.
    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        hit_mask = '0;
        hit_len  = '0;
        for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--) begin
            if (tbl_char_q[i*8 +: 8] == sym_char) begin
                hit      = 1'b1;
                hit_code = tbl_code_q[i*CODE_W +: CODE_W];
                hit_mask = tbl_mask_q[i*CODE_W +: CODE_W];
            end
        end
        for (int j = 0; j < CODE_W; j++) begin
            hit_len = hit_len + LEN_W'(hit_mask[j]);
        end
    end

    // Append the matched code directly below the current fill point (acc is MSB-aligned).
    always_comb begin
        len_ext  = FILL_W'(hit_len);
        shamt    = ACC_W_F - fill_q - len_ext;
        code_ext = ACC_W'(hit_code & hit_mask);
        acc_app  = acc_q;
        fill_app = fill_q;
        if (accept && hit) begin
            acc_app  = acc_q | (code_ext << shamt);
            fill_app = fill_q + len_ext;
        end
    end

    // Next state and datapath: word issue works on post-append values for single-cycle latency.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_app;
        fill_d  = fill_app;
        ov_d    = out_valid_q && !out_ready;
        ol_d    = out_last_q && ov_d;
        od_d    = out_data_q;
        onb_d   = out_nbits_q;
        miss_d  = miss_q || (accept && !hit);
        case (state_q)
            RUN: begin
                if (accept && sym_last) begin
                    state_d = FLUSH;
                end
                if ((fill_app >= OUT_W_F) && slot_free) begin
                    ov_d   = 1'b1;
                    od_d   = acc_app[ACC_W-1 -: OUT_W];
                    onb_d  = OUT_W_NB;
                    ol_d   = flushing && (fill_app == OUT_W_F);
                    acc_d  = acc_app << OUT_W;
                    fill_d = fill_app - OUT_W_F;
                end
            end
            FLUSH: begin
                if (out_valid_q && out_last_q) begin
                    // Final word outstanding: wait for it to drain, then go back to accepting.
                    if (out_ready) begin
                        state_d = RUN;
                        acc_d   = '0;
                        fill_d  = '0;
                    end
                end else if (slot_free) begin
                    if (fill_app >= OUT_W_F) begin
                        ov_d   = 1'b1;
                        od_d   = acc_app[ACC_W-1 -: OUT_W];
                        onb_d  = OUT_W_NB;
                        ol_d   = (fill_app == OUT_W_F);
                        acc_d  = acc_app << OUT_W;
                        fill_d = fill_app - OUT_W_F;
                    end else begin
                        // Partial (possibly empty) tail word; unused low bits are already zero.
                        ov_d   = 1'b1;
                        od_d   = acc_app[ACC_W-1 -: OUT_W];
                        onb_d  = NB_W'(fill_app);
                        ol_d   = 1'b1;
                        acc_d  = '0;
                        fill_d = '0;
                    end
                end
            end
            default: ;
        endcase
        // A table load is a soft restart and overrides everything else this cycle.
        if (tbl_load) begin
            state_d = RUN;
            acc_d   = '0;
            fill_d  = '0;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
            od_d    = '0;
            onb_d   = '0;
            miss_d  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Table capture, accumulator and output word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_char_q  <= '0;
            tbl_code_q  <= '0;
            tbl_mask_q  <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_nbits_q <= '0;
            out_last_q  <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            if (tbl_load) begin
                tbl_char_q <= tbl_char;
                tbl_code_q <= tbl_code;
                tbl_mask_q <= tbl_mask;
            end
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= ov_d;
            out_data_q  <= od_d;
            out_nbits_q <= onb_d;
            out_last_q  <= ol_d;
            miss_q      <= miss_d;
        end
    end

endmodule

// File: tb/tb_huff_bit_packer.sv
// tb/tb_huff_bit_packer.sv - scoreboard bench for huff_bit_packer
module tb_huff_bit_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tbl_load = 1'b0;
    logic [23:0] tbl_char;
    logic [8:0]  tbl_code;
    logic [8:0]  tbl_mask;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [7:0]  sym_char = 8'h00;
    logic        sym_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [3:0]  out_nbits;
    logic        out_last;
    logic        miss_err;

    logic [7:0] tc[3];
    logic [2:0] tcode[3];
    logic [2:0] tmask[3];

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] n;
        logic       l;
    } word_t;

    word_t      exp_q[$];
    word_t      obs_q[$];
    logic [7:0] m[$];
    int         total = 0;
    int         bad = 0;

    assign tbl_char = {tc[2], tc[1], tc[0]};
    assign tbl_code = {tcode[2], tcode[1], tcode[0]};
    assign tbl_mask = {tmask[2], tmask[1], tmask[0]};

    huff_bit_packer dut (
        .clk       (clk),
        .reset     (reset),
        .tbl_load  (tbl_load),
        .tbl_char  (tbl_char),
        .tbl_code  (tbl_code),
        .tbl_mask  (tbl_mask),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_char  (sym_char),
        .sym_last  (sym_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nbits (out_nbits),
        .out_last  (out_last),
        .miss_err  (miss_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // Reference packer: builds the message bit string from the table, then slices it into words.
    task automatic model_msg(input logic [7:0] msg[$]);
        bit         b[$];
        int         idx;
        int         len;
        int         nw;
        int         nb;
        logic [7:0] w;
        foreach (msg[s]) begin
            idx = -1;
            for (int k = 2; k >= 0; k--) begin
                if (tc[k] == msg[s]) idx = k;
            end
            if (idx >= 0) begin
                len = $countones(tmask[idx]);
                for (int j = len - 1; j >= 0; j--) b.push_back(tcode[idx][j]);
            end
        end
        nw = 0;
        while (b.size() >= 8) begin
            w = 8'h00;
            for (int j = 0; j < 8; j++) w = {w[6:0], b.pop_front()};
            exp_q.push_back({w, 4'd8, (b.size() == 0)});
            nw++;
        end
        if (b.size() > 0 || nw == 0) begin
            nb = b.size();
            w  = 8'h00;
            for (int j = 0; j < 8; j++) w = {w[6:0], (j < nb) ? b[j] : 1'b0};
            exp_q.push_back({w, 4'(nb), 1'b1});
        end
    endtask

    task automatic send_sym(input logic [7:0] c, input logic l);
        int t;
        t = 0;
        sym_valid = 1'b1;
        sym_char  = c;
        sym_last  = l;
        forever begin
            @(negedge clk);
            if (sym_ready) break;
            t++;
            if (t > 200) begin
                chk("sym_accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        model_msg(msg);
        foreach (msg[i]) send_sym(msg[i], i == msg.size() - 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic load_tbl();
        @(posedge clk);
        #1;
        tbl_load = 1'b1;
        @(posedge clk);
        #1;
        tbl_load = 1'b0;
    endtask

    // Output monitor: hold-stability check and scoreboard pop on each handshake.
    logic       hold_prev = 1'b0;
    logic [7:0] hold_d;
    logic [3:0] hold_n;
    logic       hold_l;
    word_t      wexp;
    always @(negedge clk) begin
        if (hold_prev && !reset) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_word", {out_data, out_nbits, out_last}, {hold_d, hold_n, hold_l});
        end
        hold_prev = out_valid && !out_ready && !reset && !tbl_load;
        hold_d    = out_data;
        hold_n    = out_nbits;
        hold_l    = out_last;
        if (out_valid && out_ready && !reset) begin
            obs_q.push_back({out_data, out_nbits, out_last});
            if (exp_q.size() == 0) begin
                chk("extra_word", 1, 0);
            end else begin
                wexp = exp_q.pop_front();
                chk("word_data", out_data, wexp.d);
                chk("word_nbits", out_nbits, wexp.n);
                chk("word_last", out_last, wexp.l);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tc    = '{8'h61, 8'h62, 8'h63};
        tcode = '{3'b000, 3'b010, 3'b011};
        tmask = '{3'b001, 3'b011, 3'b011};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nbits", out_nbits, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_miss_err", miss_err, 0);

        // IDLE refuses characters until a table arrives.
        reset = 1'b0;
        sym_valid = 1'b1;
        sym_char  = 8'h61;
        @(posedge clk);
        #1;
        chk("idle_sym_ready", sym_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        sym_valid = 1'b0;
        load_tbl();
        chk("run_sym_ready", sym_ready, 1);

        // Scenario 1: a,b,c,a,b,c.
        obs_q.delete();
        m = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
        send_msg(m);
        drain();
        chk("s1_count", obs_q.size(), 2);
        chk("s1_w0", obs_q[0], {8'h5A, 4'd8, 1'b0});
        chk("s1_w1", obs_q[1], {8'hC0, 4'd2, 1'b1});

        // Scenario 2: exactly one full word, marked last.
        obs_q.delete();
        m = '{8'h62, 8'h63, 8'h62, 8'h63};
        send_msg(m);
        drain();
        chk("s2_count", obs_q.size(), 1);
        chk("s2_w0", obs_q[0], {8'hBB, 4'd8, 1'b1});

        // Scenario 3: consumer stalls; second word fills up behind the held first word.
        obs_q.delete();
        m = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h62, 8'h63, 8'h62, 8'h63};
        out_ready = 1'b0;
        fork
            send_msg(m);
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("stall_sym_ready", sym_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_out_data", out_data, 8'h5A);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("s3_count", obs_q.size(), 3);
        chk("s3_w1", obs_q[1], {8'hEE, 4'd8, 1'b0});
        chk("s3_w2", obs_q[2], {8'hC0, 4'd2, 1'b1});

        // Scenario 4: unknown character sets miss_err and contributes no bits.
        obs_q.delete();
        m = '{8'h7A, 8'h61};
        send_msg(m);
        drain();
        chk("s4_miss", miss_err, 1);
        chk("s4_count", obs_q.size(), 1);
        chk("s4_w0", obs_q[0], {8'h00, 4'd1, 1'b1});
        obs_q.delete();
        m = '{8'h7A};
        send_msg(m);
        drain();
        chk("s4b_count", obs_q.size(), 1);
        chk("s4b_w0", obs_q[0], {8'h00, 4'd0, 1'b1});
        chk("s4b_miss", miss_err, 1);

        // Scenario 5: asynchronous reset in the middle of a message.
        send_sym(8'h61, 1'b0);
        send_sym(8'h62, 1'b0);
        send_sym(8'h63, 1'b0);
        reset = 1'b1;
        #1;
        chk("s5_sym_ready", sym_ready, 0);
        chk("s5_out_valid", out_valid, 0);
        chk("s5_out_data", out_data, 0);
        chk("s5_out_nbits", out_nbits, 0);
        chk("s5_out_last", out_last, 0);
        chk("s5_miss", miss_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("s5_idle_ready", sym_ready, 0);
        load_tbl();

        // Scenario 6: table load discards a pending word and clears miss_err.
        out_ready = 1'b0;
        send_sym(8'h7A, 1'b0);
        send_sym(8'h61, 1'b0);
        send_sym(8'h62, 1'b0);
        send_sym(8'h63, 1'b0);
        send_sym(8'h61, 1'b0);
        send_sym(8'h62, 1'b0);
        @(posedge clk);
        #1;
        chk("s6_pending", out_valid, 1);
        chk("s6_miss_before", miss_err, 1);
        load_tbl();
        chk("s6_out_valid", out_valid, 0);
        chk("s6_miss_after", miss_err, 0);
        chk("s6_sym_ready", sym_ready, 1);
        out_ready = 1'b1;
        obs_q.delete();
        m = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
        send_msg(m);
        drain();
        chk("s6_count", obs_q.size(), 2);
        chk("s6_w0", obs_q[0], {8'h5A, 4'd8, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
